// File: rtl/disp_vramrd.sv
// rtl/disp_vramrd.sv - AXI4 read master streaming one VRAM display frame per VRSTART into the display FIFO
// Optional feature macro: DISP_VRAMRD_ERRCHK_EN (sticky RERR on RRESP[1] beats; otherwise RERR is 0).
module disp_vramrd #(
  parameter int DATA_W    = 64,
  parameter int BURST_LEN = 8,
  parameter int MAX_OUTST = 2
) (
  input  logic              ACLK,
  input  logic              ARST,
  output logic [31:0]       ARADDR,
  output logic [7:0]        ARLEN,
  output logic              ARVALID,
  input  logic              ARREADY,
  input  logic [DATA_W-1:0] RDATA,
  input  logic [1:0]        RRESP,
  input  logic              RLAST,
  input  logic              RVALID,
  output logic              RREADY,
  input  logic [1:0]        RESOL,
  input  logic              VRSTART,
  input  logic              DISPON,
  input  logic [28:0]       DISPADDR,
  input  logic              BUF_WREADY,
  output logic [DATA_W-1:0] BUF_WDATA,
  output logic              BUF_WE,
  output logic              BUSY,
  output logic              FRAME_DONE,
  output logic              OVERRUN,
  output logic              RERR
);
  localparam int BURST_BYTES = BURST_LEN * DATA_W / 8;
  localparam logic [16:0] NB_VGA  = 17'(640 * 480 * 4 / BURST_BYTES);
  localparam logic [16:0] NB_XGA  = 17'(1024 * 768 * 4 / BURST_BYTES);
  localparam logic [16:0] NB_SXGA = 17'(1280 * 1024 * 4 / BURST_BYTES);
  localparam logic [31:0] BB32    = 32'(BURST_BYTES);
  localparam logic [2:0]  MAXO    = 3'(MAX_OUTST);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ADDR  = 2'd1;
  localparam logic [1:0] S_HOLD  = 2'd2;
  localparam logic [1:0] S_DRAIN = 2'd3;

  logic [1:0]  state;
  logic [16:0] n;
  logic [2:0]  oc;
  logic [2:0]  oc_nxt;
  logic [1:0]  resol_q;
  logic [16:0] nburst;
  logic        aborted;
  logic        ar_hs;
  logic        r_end;
  logic        start;
  logic        unused_rresp;

  assign ARLEN     = 8'(BURST_LEN - 1);
  assign BUSY      = (state != S_IDLE);
  assign RREADY    = BUSY;
  assign BUF_WE    = RVALID & RREADY;
  assign BUF_WDATA = RDATA;
  assign ar_hs     = ARVALID & ARREADY;
  assign r_end     = BUF_WE & RLAST;
  assign start     = VRSTART & DISPON & ~BUSY;
  assign unused_rresp = ^RRESP;

  always_comb begin
    nburst = NB_VGA;
    case (resol_q)
      2'b01:   nburst = NB_XGA;
      2'b10:   nburst = NB_SXGA;
      default: nburst = NB_VGA;
    endcase
  end

  // An AR and an RLAST in the same cycle cancel out.
  always_comb begin
    oc_nxt = oc;
    if (ar_hs && !r_end)
      oc_nxt = oc + 3'd1;
    else if (!ar_hs && r_end && oc != 3'd0)
      oc_nxt = oc - 3'd1;
  end

  always_ff @(posedge ACLK) begin
    if (ARST) begin
      state      <= S_IDLE;
      n          <= '0;
      oc         <= '0;
      resol_q    <= '0;
      aborted    <= 1'b0;
      ARVALID    <= 1'b0;
      ARADDR     <= '0;
      FRAME_DONE <= 1'b0;
      OVERRUN    <= 1'b0;
    end else begin
      oc         <= oc_nxt;
      FRAME_DONE <= 1'b0;
      OVERRUN    <= VRSTART & BUSY;
      if (BUSY && !DISPON)
        aborted <= 1'b1;
      // ARADDR always points one burst past the last accepted one.
      if (ar_hs) begin
        n      <= n + 17'd1;
        ARADDR <= ARADDR + BB32;
      end
      case (state)
        S_IDLE: begin
          if (start) begin
            state   <= S_ADDR;
            n       <= '0;
            oc      <= '0;
            resol_q <= RESOL;
            aborted <= 1'b0;
            ARVALID <= 1'b1;
            ARADDR  <= {DISPADDR, 3'b000};
          end
        end
        S_ADDR: begin
          if (ar_hs) begin
            if (n + 17'd1 == nburst || !DISPON) begin
              state   <= S_DRAIN;
              ARVALID <= 1'b0;
            end else if (!(BUF_WREADY && oc + 3'd1 < MAXO)) begin
              state   <= S_HOLD;
              ARVALID <= 1'b0;
            end
          end
        end
        S_HOLD: begin
          if (!DISPON) begin
            state <= S_DRAIN;
          end else if (BUF_WREADY && oc < MAXO) begin
            state   <= S_ADDR;
            ARVALID <= 1'b1;
          end
        end
        S_DRAIN: begin
          // Leave as the last RLAST is accepted so BUSY falls with FRAME_DONE.
          if (oc_nxt == 3'd0) begin
            state      <= S_IDLE;
            FRAME_DONE <= (n == nburst) && !aborted && DISPON;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

`ifdef DISP_VRAMRD_ERRCHK_EN
  always_ff @(posedge ACLK) begin
    if (ARST || start)
      RERR <= 1'b0;
    else if (BUF_WE && RRESP[1])
      RERR <= 1'b1;
  end
`else
  assign RERR = 1'b0;
`endif

endmodule

// File: tb/tb_disp_vramrd.sv
// tb/tb_disp_vramrd.sv - randomized self-checking bench for disp_vramrd with a frame-level reference model
`timescale 1ns/1ps
module tb_disp_vramrd;
  localparam int DATA_W = 64, BURST_LEN = 8, MAX_OUTST = 2, BB = 64;
`ifdef DISP_VRAMRD_ERRCHK_EN
  localparam logic ERRCHK = 1'b1;
`else
  localparam logic ERRCHK = 1'b0;
`endif

  logic ACLK = 1'b0, ARST = 1'b1;
  logic [31:0] ARADDR;
  logic [7:0]  ARLEN;
  logic ARVALID, ARREADY = 1'b0;
  logic [DATA_W-1:0] RDATA = '0;
  logic [1:0] RRESP = '0;
  logic RLAST = 1'b0, RVALID = 1'b0, RREADY;
  logic [1:0] RESOL = '0;
  logic VRSTART = 1'b0, DISPON = 1'b0;
  logic [28:0] DISPADDR = '0;
  logic BUF_WREADY = 1'b1;
  logic [DATA_W-1:0] BUF_WDATA;
  logic BUF_WE, BUSY, FRAME_DONE, OVERRUN, RERR;

  always #5 ACLK = ~ACLK;

  disp_vramrd #(.DATA_W(DATA_W), .BURST_LEN(BURST_LEN), .MAX_OUTST(MAX_OUTST)) dut (
    .ACLK(ACLK), .ARST(ARST), .ARADDR(ARADDR), .ARLEN(ARLEN), .ARVALID(ARVALID),
    .ARREADY(ARREADY), .RDATA(RDATA), .RRESP(RRESP), .RLAST(RLAST), .RVALID(RVALID),
    .RREADY(RREADY), .RESOL(RESOL), .VRSTART(VRSTART), .DISPON(DISPON),
    .DISPADDR(DISPADDR), .BUF_WREADY(BUF_WREADY), .BUF_WDATA(BUF_WDATA), .BUF_WE(BUF_WE),
    .BUSY(BUSY), .FRAME_DONE(FRAME_DONE), .OVERRUN(OVERRUN), .RERR(RERR)
  );

  int checks = 0, failures = 0;
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Reference model: frame bookkeeping from handshakes, updated ahead of each rising edge.
  int oc_m = 0, ar_count = 0, nburst_m = 0, ar_total = 0, rl_total = 0;
  int fd_count = 0, we_count = 0, ov_count = 0;
  logic [31:0] base_m = '0, first_addr = '0, second_addr = '0, last_addr = '0, p_araddr = '0;
  logic aborted_m = 1'b0, fd_exp = 1'b0, ov_exp = 1'b0, rerr_exp = 1'b0, r_took = 1'b0;
  logic p_arvalid = 1'b0, p_arready = 1'b0, p_start = 1'b0, p_dispon = 1'b0, p_bufw = 1'b0, p_arst = 1'b1;

  initial begin : compare
    logic ar_hs, r_hs, r_end, start, newar, fd_next;
    logic [31:0] exp_addr;
    @(posedge ACLK);
    forever begin
      @(negedge ACLK);
      check("rready", RREADY, BUSY);
      check("buf_we", BUF_WE, RVALID & BUSY);
      if (BUF_WE) check("buf_wdata", BUF_WDATA, RDATA);
      check("frame_done", FRAME_DONE, fd_exp);
      if (FRAME_DONE) begin fd_count++; check("busy_at_done", BUSY, 0); end
      check("overrun", OVERRUN, ov_exp);
      if (OVERRUN) ov_count++;
      check("rerr", RERR, rerr_exp);
      if (!p_arst) begin
        if (p_start) check("ar_after_start", ARVALID, 1);
        if (p_arvalid && !p_arready) begin
          check("ar_hold_valid", ARVALID, 1);
          check("ar_hold_addr", ARADDR, p_araddr);
        end
        newar = ARVALID && (!p_arvalid || p_arready);
        if (newar && ar_count > 0) check("ar_gate", p_dispon & p_bufw, 1);
      end
      if (ARVALID) begin
        exp_addr = base_m + 32'(ar_count * BB);
        check("araddr", ARADDR, exp_addr);
        check("arlen", ARLEN, 8'd7);
        check("ar_count_limit", ar_count < nburst_m, 1);
      end
      ar_hs = ARVALID & ARREADY;
      r_hs  = RVALID & RREADY;
      r_end = r_hs & RLAST;
      start = VRSTART & DISPON & !BUSY;
      r_took = r_hs;
      fd_next = 1'b0;
      ov_exp = VRSTART & BUSY & !ARST;
      if (ARST) begin
        oc_m = 0; ar_count = 0; aborted_m = 1'b0; rerr_exp = 1'b0;
      end else begin
        if (r_hs) we_count++;
        if (r_hs && RRESP[1] && ERRCHK) rerr_exp = 1'b1;
        if (ar_hs) begin
          if (ar_count == 0) first_addr = ARADDR;
          if (ar_count == 1) second_addr = ARADDR;
          last_addr = ARADDR;
          ar_count++; ar_total++; oc_m++;
        end
        if (r_end) begin rl_total++; oc_m--; end
        check("oc_limit", oc_m <= MAX_OUTST, 1);
        if (BUSY && !DISPON) aborted_m = 1'b1;
        if (BUSY && r_end && oc_m == 0 && ar_count == nburst_m && !aborted_m) fd_next = 1'b1;
        if (start) begin
          base_m = {DISPADDR, 3'b000};
          ar_count = 0;
          aborted_m = 1'b0;
          rerr_exp = 1'b0;
          nburst_m = (RESOL == 2'b01) ? 49152 : (RESOL == 2'b10) ? 81920 : 19200;
        end
      end
      fd_exp = fd_next;
      p_arvalid = ARVALID; p_arready = ARREADY; p_araddr = ARADDR;
      p_start = start & !ARST; p_dispon = DISPON; p_bufw = BUF_WREADY; p_arst = ARST;
    end
  end

  // Slave and buffer driver knobs.
  int ar_pct = 100, rv_pct = 100, bw_pct = 100, beats = 8, rbeat = 0;
  logic err_once = 1'b0;

  task automatic step();
    @(posedge ACLK); #1;
    if (!(RVALID && !r_took)) begin
      if (r_took) rbeat = RLAST ? 0 : rbeat + 1;
      if (oc_m > 0 && $urandom_range(99) < rv_pct) begin
        RVALID = 1'b1;
        RDATA  = {$urandom, $urandom};
        RLAST  = (rbeat == beats - 1);
        RRESP  = err_once ? 2'b10 : 2'b00;
        err_once = 1'b0;
      end else begin
        RVALID = 1'b0; RLAST = 1'b0; RRESP = 2'b00;
      end
    end
    ARREADY    = ($urandom_range(99) < ar_pct);
    BUF_WREADY = ($urandom_range(99) < bw_pct);
  endtask

  task automatic start_frame(input logic [28:0] a, input logic [1:0] r);
    DISPADDR = a; RESOL = r; DISPON = 1'b1; VRSTART = 1'b1;
    step();
    VRSTART = 1'b0;
  endtask

  task automatic wait_idle(input int budget, input string nm);
    int i = 0;
    while (BUSY && i < budget) begin step(); i++; end
    check({nm, "_idle"}, BUSY, 0);
    step(); step();
  endtask

  initial begin
    int ar0, we0, fd0, rl0, ov0, frozen, i, cyc;
    ARST = 1'b1;
    VRSTART = 1'($urandom); DISPON = 1'($urandom); RVALID = 1'($urandom);
    RLAST = 1'($urandom); ARREADY = 1'($urandom); DISPADDR = 29'($urandom);
    @(posedge ACLK); #1;
    VRSTART = 1'($urandom); RVALID = 1'b1; RRESP = 2'b10; BUF_WREADY = 1'($urandom);
    @(posedge ACLK);
    @(negedge ACLK);
    check("rst_arvalid", ARVALID, 0);
    check("rst_araddr", ARADDR, 0);
    check("rst_busy", BUSY, 0);
    check("rst_frame_done", FRAME_DONE, 0);
    check("rst_overrun", OVERRUN, 0);
    check("rst_rerr", RERR, 0);
    check("rst_buf_we", BUF_WE, 0);
    check("rst_rready", RREADY, 0);
    @(posedge ACLK); #1;
    ARST = 1'b0; VRSTART = 1'b0; RVALID = 1'b0; RLAST = 1'b0; RRESP = 2'b00; DISPON = 1'b1;
    step(); step();

    // Full VGA frame with single-beat responses to stay within the cycle budget.
    beats = 1; ar_pct = 100; rv_pct = 100; bw_pct = 100;
    ar0 = ar_total; we0 = we_count; fd0 = fd_count;
    start_frame(29'h0100_0000, 2'b00);
    wait_idle(60000, "vga");
    check("vga_first_addr", first_addr, 32'h0800_0000);
    check("vga_second_addr", second_addr, 32'h0800_0040);
    check("vga_last_addr", last_addr, 32'h0812_BFC0);
    check("vga_ar_count", ar_total - ar0, 19200);
    check("vga_we_count", we_count - we0, 19200);
    check("vga_frame_done", fd_count - fd0, 1);

    // Outstanding limit.
    beats = 8; rv_pct = 0; ar0 = ar_total; fd0 = fd_count;
    start_frame(29'($urandom), 2'b01);
    repeat (20) step();
    check("outst_two_ar", ar_total - ar0, 2);
    check("outst_arvalid_low", ARVALID, 0);
    rl0 = rl_total; rv_pct = 100; i = 0;
    while (i < 50) begin
      @(negedge ACLK); #1;
      if (rl_total != rl0) break;
      step(); i++;
    end
    rv_pct = 0;
    check("outst_one_rlast", rl_total - rl0, 1);
    repeat (20) step();
    check("outst_third_ar", ar_total - ar0, 3);
    check("outst_arvalid_low2", ARVALID, 0);
    DISPON = 1'b0; rv_pct = 100;
    wait_idle(300, "outst");
    check("outst_no_done", fd_count - fd0, 0);

    // Buffer back-pressure.
    fd0 = fd_count;
    start_frame(29'($urandom), 2'b10);
    i = 0;
    while (ar_count < 5 && i < 500) begin step(); i++; end
    check("bp_reach5", ar_count >= 5, 1);
    bw_pct = 0;
    repeat (4) step();
    frozen = ar_count;
    repeat (30) step();
    check("bp_no_ar", ar_count, frozen);
    check("bp_arvalid_low", ARVALID, 0);
    bw_pct = 100; i = 0;
    while (ar_count == frozen && i < 50) begin step(); i++; end
    check("bp_resume_addr", last_addr, base_m + 32'(frozen * BB));
    DISPON = 1'b0;
    wait_idle(300, "bp");

    // Abort after 100 bursts.
    ar_pct = 80; rv_pct = 90;
    start_frame(29'($urandom), 2'b01);
    i = 0;
    while (ar_count < 100 && i < 3000) begin step(); i++; end
    check("abort_reach100", ar_count >= 100, 1);
    DISPON = 1'b0; ar0 = ar_total;
    wait_idle(500, "abort");
    check("abort_ar_after", ar_total - ar0 <= 1, 1);
    check("abort_all_rlast", oc_m, 0);
    check("abort_no_done", fd_count - fd0, 0);

    // Overrun and error response.
    ar_pct = 100; rv_pct = 100;
    start_frame(29'($urandom), 2'b00);
    repeat (10) step();
    ov0 = ov_count;
    VRSTART = 1'b1; step(); VRSTART = 1'b0; step();
    check("overrun_pulse", ov_count - ov0, 1);
    check("overrun_busy", BUSY, 1);
    ar0 = ar_total;
    err_once = 1'b1;
    repeat (20) step();
    check("overrun_fetch_goes_on", ar_total > ar0, 1);
    check("rerr_set", RERR, ERRCHK);
    DISPON = 1'b0;
    wait_idle(300, "err");
    check("rerr_sticky", RERR, ERRCHK);
    start_frame(29'($urandom), 2'b00);
    check("rerr_clear_on_start", RERR, 0);
    DISPON = 1'b0;
    wait_idle(300, "err2");

    // Randomized frames, aborted at random points.
    for (int f = 0; f < 4; f++) begin
      ar_pct = $urandom_range(100, 50); rv_pct = $urandom_range(100, 50);
      bw_pct = $urandom_range(100, 60); beats = 1 << $urandom_range(3, 0);
      start_frame(29'($urandom), 2'($urandom));
      cyc = $urandom_range(400, 150);
      for (int k = 0; k < cyc; k++) begin
        if ($urandom_range(49) == 0) VRSTART = 1'b1;
        step();
        VRSTART = 1'b0;
      end
      DISPON = 1'b0; bw_pct = 100; rv_pct = 100;
      wait_idle(2000, "rand");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
